// File: rtl/pool_pkg.sv
// Shared types and sizing helpers for the streaming pooling engine.
// POOL_AVG_EN widens the accumulator so that average pooling can be built.
package pool_pkg;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DRAIN,
    FIN
  } pool_state_e;

  typedef enum logic {
    POOL_MAX,
    POOL_AVG
  } pool_mode_e;

  // Bits needed to hold the values 0..n-1, never less than one bit.
  function automatic int unsigned cnt_w(input int unsigned n);
    return (n < 2) ? 1 : $clog2(n);
  endfunction

  // The sum of P*P samples needs 2*log2(P) guard bits above the sample width.
  function automatic int unsigned pool_acc_w(input int unsigned data_w, input int unsigned p);
`ifdef POOL_AVG_EN
    return data_w + 2 * $clog2(p);
`else
    return data_w;
`endif
  endfunction

endpackage

// File: rtl/pool_stream_engine_if.sv
// Start/status controls plus the input and output valid/ready streams of the engine.
interface pool_stream_engine_if #(
  parameter int DATA_W = 16
);
  logic                     start;
  logic                     mode;
  logic                     in_valid;
  logic signed [DATA_W-1:0] in_data;
  logic                     in_ready;
  logic                     out_valid;
  logic signed [DATA_W-1:0] out_data;
  logic                     out_ready;
  logic                     busy;
  logic                     done;

  modport master (
    output start, mode, in_valid, in_data, out_ready,
    input  in_ready, out_valid, out_data, busy, done
  );

  modport slave (
    input  start, mode, in_valid, in_data, out_ready,
    output in_ready, out_valid, out_data, busy, done
  );
endinterface

// File: rtl/pool_row_buffer.sv
// One accumulator per horizontal window: combinational read, synchronous write.
module pool_row_buffer
  import pool_pkg::*;
#(
  parameter int DEPTH = 13,
  parameter int AW    = 4,
  parameter int W     = 16
) (
  input  logic                clk,
  input  logic [AW-1:0]       rd_addr,
  output logic signed [W-1:0] rd_data,
  input  logic                wr_en,
  input  logic [AW-1:0]       wr_addr,
  input  logic signed [W-1:0] wr_data
);

  localparam int IW = cnt_w(DEPTH);

  logic signed [W-1:0] mem_q [DEPTH];
  logic [IW-1:0]       rd_idx;
  logic [IW-1:0]       wr_idx;

  assign rd_idx = rd_addr[IW-1:0];
  assign wr_idx = wr_addr[IW-1:0];

  // Address DEPTH is the discard slot; reads there return zero and are never used.
  assign rd_data = (rd_addr < AW'(DEPTH)) ? mem_q[rd_idx] : '0;

  always_ff @(posedge clk) begin
    if (wr_en && (wr_addr < AW'(DEPTH))) begin
      mem_q[wr_idx] <= wr_data;
    end
  end

endmodule

// File: rtl/pool_stream_engine.sv
// Streaming P x P / stride-P pooling over a raster M x M map with a one-deep output register.
// POOL_AVG_EN adds average mode (sum of the window, arithmetic shift by 2*log2(P)).
module pool_stream_engine
  import pool_pkg::*;
#(
  parameter int M      = 26,
  parameter int P      = 2,
  parameter int DATA_W = 16
) (
  input  logic          clk,
  input  logic          external_reset_n,
  pool_stream_engine_if.slave bus
);

  localparam int Q     = M / P;
  localparam int ACC_W = pool_acc_w(DATA_W, P);
  localparam int CP_W  = cnt_w(P);
  localparam int WC_W  = cnt_w(Q + 1);
  localparam int COL_W = cnt_w(M);

  localparam logic [CP_W-1:0]  CP_LAST  = CP_W'(P - 1);
  localparam logic [WC_W-1:0]  WC_END   = WC_W'(Q);
  localparam logic [COL_W-1:0] COL_LAST = COL_W'(M - 1);

  if ((M < 2) || (M > 256)) begin : g_bad_m
    $error("pool_stream_engine: M must lie in 2..256");
  end
  if ((P < 2) || (P > M)) begin : g_bad_p
    $error("pool_stream_engine: P must lie in 2..M");
  end
`ifdef POOL_AVG_EN
  localparam int SHIFT = 2 * $clog2(P);
  if ((P & (P - 1)) != 0) begin : g_bad_p_pow2
    $error("pool_stream_engine: average pooling needs P to be a power of two");
  end
`endif

  pool_state_e               state_q, state_d;
  logic [CP_W-1:0]           cp_q, cp_d, rp_q, rp_d;
  logic [WC_W-1:0]           wc_q, wc_d, wr_q, wr_d;
  logic [COL_W-1:0]          col_q, col_d, row_q, row_d;
  logic                      out_valid_q, out_valid_d;
  logic signed [DATA_W-1:0]  out_data_q, out_data_d;
  logic signed [DATA_W-1:0]  result;
  logic                      in_ready, in_hs, out_hs;
  logic                      keep, first_smp, acc_we, win_done, last_smp;
  logic signed [ACC_W-1:0]   samp_ext, acc_rd, acc_new;
`ifdef POOL_AVG_EN
  pool_mode_e                mode_q, mode_d;
`else
  logic                      unused_mode;
  assign unused_mode = bus.mode;
`endif

  function automatic logic signed [ACC_W-1:0] acc_max(input logic signed [ACC_W-1:0] a,
                                                     input logic signed [ACC_W-1:0] b);
    return (b > a) ? b : a;
  endfunction

`ifdef POOL_AVG_EN
  // Arithmetic shift rounds toward minus infinity; the quotient always fits DATA_W.
  function automatic logic signed [DATA_W-1:0] avg_floor(input logic signed [ACC_W-1:0] sum);
    logic signed [ACC_W-1:0] quo;
    quo = sum >>> SHIFT;
    return quo[DATA_W-1:0];
  endfunction
`endif

  assign in_ready  = (state_q == RUN) && (!out_valid_q || bus.out_ready);
  assign in_hs     = bus.in_valid && in_ready;
  assign out_hs    = out_valid_q && bus.out_ready;
  assign keep      = (wc_q != WC_END) && (wr_q != WC_END);
  assign first_smp = (cp_q == '0) && (rp_q == '0);
  assign acc_we    = in_hs && keep;
  assign win_done  = acc_we && (cp_q == CP_LAST) && (rp_q == CP_LAST);
  assign last_smp  = (col_q == COL_LAST) && (row_q == COL_LAST);
  assign samp_ext  = ACC_W'(bus.in_data);

  pool_row_buffer #(
    .DEPTH (Q),
    .AW    (WC_W),
    .W     (ACC_W)
  ) u_row_buffer (
    .clk     (clk),
    .rd_addr (wc_q),
    .rd_data (acc_rd),
    .wr_en   (acc_we),
    .wr_addr (wc_q),
    .wr_data (acc_new)
  );

  always_comb begin
    acc_new     = samp_ext;
    result      = '0;
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
`ifdef POOL_AVG_EN
    if (!first_smp) begin
      acc_new = (mode_q == POOL_AVG) ? (acc_rd + samp_ext) : acc_max(acc_rd, samp_ext);
    end
    result = (mode_q == POOL_AVG) ? avg_floor(acc_new) : acc_new[DATA_W-1:0];
`else
    if (!first_smp) begin
      acc_new = acc_max(acc_rd, samp_ext);
    end
    result = acc_new[DATA_W-1:0];
`endif
    // A completing window in the same cycle as a drain overwrites without a bubble.
    if (out_hs) begin
      out_valid_d = 1'b0;
    end
    if (win_done) begin
      out_valid_d = 1'b1;
      out_data_d  = result;
    end
  end

  always_comb begin
    state_d = state_q;
    cp_d    = cp_q;
    wc_d    = wc_q;
    rp_d    = rp_q;
    wr_d    = wr_q;
    col_d   = col_q;
    row_d   = row_q;
`ifdef POOL_AVG_EN
    mode_d  = mode_q;
`endif
    case (state_q)
      IDLE: begin
        if (bus.start) begin
          state_d = RUN;
          cp_d    = '0;
          wc_d    = '0;
          rp_d    = '0;
          wr_d    = '0;
          col_d   = '0;
          row_d   = '0;
`ifdef POOL_AVG_EN
          mode_d  = bus.mode ? POOL_AVG : POOL_MAX;
`endif
        end
      end
      RUN: begin
        if (in_hs) begin
          if (col_q == COL_LAST) begin
            col_d = '0;
            cp_d  = '0;
            wc_d  = '0;
            row_d = (row_q == COL_LAST) ? '0 : row_q + 1'b1;
            if (rp_q == CP_LAST) begin
              rp_d = '0;
              if (wr_q != WC_END) wr_d = wr_q + 1'b1;
            end else begin
              rp_d = rp_q + 1'b1;
            end
          end else begin
            col_d = col_q + 1'b1;
            // Once wc reaches Q the rest of the row is discarded.
            if (cp_q == CP_LAST) begin
              cp_d = '0;
              if (wc_q != WC_END) wc_d = wc_q + 1'b1;
            end else begin
              cp_d = cp_q + 1'b1;
            end
          end
          if (last_smp) state_d = DRAIN;
        end
      end
      DRAIN: begin
        if (!out_valid_q || out_hs) state_d = FIN;
      end
      FIN: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge external_reset_n) begin
    if (!external_reset_n) begin
      state_q     <= IDLE;
      cp_q        <= '0;
      wc_q        <= '0;
      rp_q        <= '0;
      wr_q        <= '0;
      col_q       <= '0;
      row_q       <= '0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
`ifdef POOL_AVG_EN
      mode_q      <= POOL_MAX;
`endif
    end else begin
      state_q     <= state_d;
      cp_q        <= cp_d;
      wc_q        <= wc_d;
      rp_q        <= rp_d;
      wr_q        <= wr_d;
      col_q       <= col_d;
      row_q       <= row_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
`ifdef POOL_AVG_EN
      mode_q      <= mode_d;
`endif
    end
  end

  assign bus.in_ready  = in_ready;
  assign bus.out_valid = out_valid_q;
  assign bus.out_data  = out_data_q;
  assign bus.busy      = (state_q == RUN) || (state_q == DRAIN);
  assign bus.done      = (state_q == FIN);

endmodule

// File: tb/tb_pool_stream_engine.sv
// Bench for pool_stream_engine: one M=4 and one M=5 instance (P=2), vector table plus
// scoreboard of expected pooled results; POOL_AVG_EN adds the average-mode vectors.
module tb_pool_stream_engine;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic                external_reset_n;
  logic                sel;
  logic                start;
  logic                mode;
  logic                in_valid;
  logic signed [15:0]  in_data;
  logic                out_ready = 1'b1;

  pool_stream_engine_if #(.DATA_W(16)) if4 ();
  pool_stream_engine_if #(.DATA_W(16)) if5 ();

  assign if4.start     = start & ~sel;
  assign if5.start     = start & sel;
  assign if4.mode      = mode;
  assign if5.mode      = mode;
  assign if4.in_valid  = in_valid & ~sel;
  assign if5.in_valid  = in_valid & sel;
  assign if4.in_data   = in_data;
  assign if5.in_data   = in_data;
  assign if4.out_ready = out_ready;
  assign if5.out_ready = out_ready;

  pool_stream_engine #(.M(4), .P(2), .DATA_W(16)) dut4 (
    .clk              (clk),
    .external_reset_n (external_reset_n),
    .bus              (if4)
  );

  pool_stream_engine #(.M(5), .P(2), .DATA_W(16)) dut5 (
    .clk              (clk),
    .external_reset_n (external_reset_n),
    .bus              (if5)
  );

  logic               in_ready_m, out_valid_m, busy_m, done_m;
  logic signed [15:0] out_data_m;
  assign in_ready_m  = sel ? if5.in_ready  : if4.in_ready;
  assign out_valid_m = sel ? if5.out_valid : if4.out_valid;
  assign out_data_m  = sel ? if5.out_data  : if4.out_data;
  assign busy_m      = sel ? if5.busy      : if4.busy;
  assign done_m      = sel ? if5.done      : if4.done;

  typedef struct {
    int               sel;
    int               pat;
    int               md;
    int               orm;
    logic [3:0][15:0] ex;
  } vec_t;

`ifdef POOL_AVG_EN
  localparam int N_VEC = 9;
`else
  localparam int N_VEC = 7;
`endif
  vec_t vecs [N_VEC];

  int total = 0;
  int bad   = 0;

  logic signed [15:0] exp_q [$];
  int                 pops;
  int                 cyc = 0;
  bit                 hs_in;
  bit                 done_seen;
  int                 done_cyc;
  int                 last_acc;
  bit                 held;
  logic signed [15:0] held_data;
  int                 hold_cycles;
  int                 or_mode = 0;

  // out_ready generator: 0 = always ready, 1 = random, 2 = one 5-cycle hold at the first result
  bit hold_armed = 1'b1;
  int hold_left  = 0;
  always @(posedge clk) begin
    #1;
    if (or_mode == 0) begin
      out_ready = 1'b1;
    end else if (or_mode == 1) begin
      out_ready = 1'($urandom_range(0, 1));
    end else begin
      if (hold_armed && out_valid_m) begin
        hold_left  = 5;
        hold_armed = 1'b0;
      end
      if (hold_left > 0) begin
        out_ready = 1'b0;
        hold_left--;
      end else begin
        out_ready = 1'b1;
      end
    end
    if (or_mode != 2) hold_armed = 1'b1;
  end

  task automatic chk(input string name, input int got, input int want);
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL %s: got %0d, want %0d (cycle %0d)", name, got, want, cyc);
    end
  endtask

  // One clock: observe at the falling edge, return 1 time unit after the rising edge.
  task automatic step();
    @(negedge clk);
    cyc++;
    hs_in = in_valid && in_ready_m;
    if (out_valid_m && out_ready) begin
      if (exp_q.size() == 0) begin
        total++;
        bad++;
        $display("FAIL extra_output: got %0d, want no output", out_data_m);
      end else begin
        chk("result", int'(out_data_m), int'(exp_q.pop_front()));
      end
      pops++;
    end
    if (out_valid_m && !out_ready) begin
      chk("in_ready_while_held", int'(in_ready_m), 0);
      if (held) chk("held_data_stable", int'(out_data_m), int'(held_data));
      held      = 1'b1;
      held_data = out_data_m;
      hold_cycles++;
    end else begin
      held = 1'b0;
    end
    if (done_m && !done_seen) begin
      done_seen = 1'b1;
      done_cyc  = cyc;
    end
    @(posedge clk);
    #1;
  endtask

  function automatic logic signed [15:0] samp(input int pat, input int m, input int r, input int c);
    case (pat)
      0:       return 16'(r * m + c);
      1:       return ((r == 1) && (c == 1)) ? -16'sd1 : -16'sd3;
      default: return 16'(m * m - 1 - (r * m + c));
    endcase
  endfunction

  task automatic start_frame(input vec_t v);
    sel         = v.sel[0];
    mode        = v.md[0];
    or_mode     = v.orm;
    pops        = 0;
    done_seen   = 1'b0;
    hold_cycles = 0;
    held        = 1'b0;
    #1;
    chk("idle_in_ready", int'(in_ready_m), 0);
    start = 1'b1;
    step();
    start = 1'b0;
    chk("busy_after_start", int'(busy_m), 1);
    chk("in_ready_after_start", int'(in_ready_m), 1);
  endtask

  task automatic send_samples(input vec_t v, input int n);
    int m, qp, k, guard;
    m  = (v.sel != 0) ? 5 : 4;
    qp = (m / 2) * 2;
    k  = 0;
    for (int idx = 0; idx < n; idx++) begin
      int r, c;
      r        = idx / m;
      c        = idx % m;
      in_valid = 1'b1;
      in_data  = samp(v.pat, m, r, c);
      guard    = 0;
      do begin
        step();
        guard++;
      end while (!hs_in && guard < 200);
      if (!hs_in) begin
        $display("FAIL input_stall: sample %0d never accepted", idx);
        $fatal(1, "input handshake timeout");
      end
      last_acc = cyc;
      if ((r % 2 == 1) && (c % 2 == 1) && (r < qp) && (c < qp)) begin
        exp_q.push_back($signed(v.ex[k]));
        k++;
      end
    end
    in_valid = 1'b0;
  endtask

  task automatic finish_frame(input vec_t v);
    int g;
    g = 0;
    while (!done_seen && g < 300) begin
      step();
      g++;
    end
    if (!done_seen) begin
      total++;
      bad++;
      $display("FAIL done_timeout: got no done within %0d cycles, want done", g);
    end
    if (v.orm == 0) chk("done_latency", done_cyc - last_acc, 2);
    if (v.orm == 2) chk("hold_length", hold_cycles, 5);
    chk("output_count", pops, 4);
    chk("scoreboard_empty", exp_q.size(), 0);
    chk("busy_after_done", int'(busy_m), 0);
    chk("done_one_cycle", int'(done_m), 0);
  endtask

  task automatic run_vec(input vec_t v);
    int m;
    m = (v.sel != 0) ? 5 : 4;
    start_frame(v);
    send_samples(v, m * m);
    finish_frame(v);
  endtask

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_in_ready"},  int'(in_ready_m),  0);
    chk({tag, "_out_valid"}, int'(out_valid_m), 0);
    chk({tag, "_out_data"},  int'(out_data_m),  0);
    chk({tag, "_busy"},      int'(busy_m),      0);
    chk({tag, "_done"},      int'(done_m),      0);
  endtask

  initial begin
    vecs[0] = '{sel: 0, pat: 0, md: 0, orm: 0, ex: {16'd15, 16'd13, 16'd7, 16'd5}};
    vecs[1] = '{sel: 1, pat: 0, md: 0, orm: 0, ex: {16'd18, 16'd16, 16'd8, 16'd6}};
    vecs[2] = '{sel: 0, pat: 1, md: 0, orm: 0, ex: {16'hFFFD, 16'hFFFD, 16'hFFFD, 16'hFFFF}};
    vecs[3] = '{sel: 0, pat: 0, md: 0, orm: 1, ex: {16'd15, 16'd13, 16'd7, 16'd5}};
    vecs[4] = '{sel: 1, pat: 0, md: 0, orm: 1, ex: {16'd18, 16'd16, 16'd8, 16'd6}};
    vecs[5] = '{sel: 0, pat: 2, md: 0, orm: 0, ex: {16'd5, 16'd7, 16'd13, 16'd15}};
    vecs[6] = '{sel: 0, pat: 0, md: 0, orm: 2, ex: {16'd15, 16'd13, 16'd7, 16'd5}};
`ifdef POOL_AVG_EN
    vecs[7] = '{sel: 0, pat: 0, md: 1, orm: 0, ex: {16'd12, 16'd10, 16'd4, 16'd2}};
    vecs[8] = '{sel: 0, pat: 1, md: 1, orm: 0, ex: {16'hFFFD, 16'hFFFD, 16'hFFFD, 16'hFFFD}};
`endif

    external_reset_n = 1'b0;
    sel      = 1'b0;
    start    = 1'b0;
    mode     = 1'b0;
    in_valid = 1'b0;
    in_data  = '0;
    repeat (3) @(posedge clk);
    #1;
    sel = 1'b0;
    #1;
    check_reset_outputs("reset_m4");
    sel = 1'b1;
    #1;
    check_reset_outputs("reset_m5");
    external_reset_n = 1'b1;
    step();

    for (int i = 0; i < N_VEC; i++) begin
      run_vec(vecs[i]);
      step();
    end

    // Reset in the middle of a frame, right after the first window completes.
    start_frame(vecs[0]);
    send_samples(vecs[0], 6);
    chk("pre_reset_valid", int'(out_valid_m), 1);
    chk("pre_reset_data", int'(out_data_m), 5);
    external_reset_n = 1'b0;
    #1;
    check_reset_outputs("midframe_reset");
    exp_q.delete();
    held = 1'b0;
    step();
    external_reset_n = 1'b1;
    step();
    run_vec(vecs[0]);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/pool_stream_engine.md
# pool_stream_engine

Streaming 2-D pooling engine that succeeds the fixed-function pooler control unit. It owns its own datapath and row-accumulator buffer, and accepts a raster-ordered M×M feature map over a valid/ready handshake. It emits (M/P)² pooled results in raster order over a second valid/ready handshake, with stride equal to P. It sits between the convolution output stream and the next layer's input FIFO, and handles non-divisible map sizes, back-pressure and, optionally, average pooling.

## Interface
- `M`, 26: input map side; 2 ≤ M ≤ 256.
- `P`, 2: pooling window side and stride; 2 ≤ P ≤ M.
- `DATA_W`, 16: signed two's-complement sample width.
- `clk` input 1: single clock, rising edge.
- `external_reset_n` input 1: asynchronous, active-low reset.
- `start` input 1: one-cycle pulse; begins a frame when IDLE.
- `mode` input 1: 0 = max, 1 = average. Sampled on accepted `start`. Ignored (forced max) without the macro.
- `in_valid` input 1: input sample valid.
- `in_data` input DATA_W: input sample.
- `in_ready` output 1: engine accepts a sample this cycle.
- `out_valid` output 1: pooled result valid.
- `out_data` output DATA_W: pooled result.
- `out_ready` input 1: downstream accepts the result.
- `busy` output 1: high from accepted `start` until `done`.
- `done` output 1: one-cycle pulse after the final result handshake.

## Operation
- Q = M / P (floor) windows per row and per column. Samples with column ≥ Q·P or row ≥ Q·P are accepted and discarded.
- FSM states:
  - IDLE: `in_ready` = 0. `start` → RUN; clears all counters and latches `mode`.
  - RUN: accepts samples. The handshake that accepts the M·M-th sample → DRAIN.
  - DRAIN: waits for `out_valid` = 0, or for an `out_valid && out_ready` handshake → FIN.
  - FIN: `done` = 1 for one cycle, `busy` → 0 → IDLE.
- `start` in any non-IDLE state is ignored.
- Position tracking uses incrementing counters only, with no divide or modulo: `cp` (0..P-1), `wc` (0..Q, where Q means discard), `rp` (0..P-1), `wr` (0..Q), `col` (0..M-1) and `row` (0..M-1). All wrap at the row end.
- Accumulator buffer holds Q entries of ACC_W.
  - On an accepted, non-discarded sample: if `rp`=0 and `cp`=0, `acc[wc]` ← sample; otherwise `acc[wc]` ← op(`acc[wc]`, sample).
  - op is signed max, or sum when in average mode.
- The window completes on the sample with `rp`=P-1 and `cp`=P-1.
  - `out_data` ← max, or sum >>> (2·log2 P) in average mode (arithmetic shift, rounds toward −∞).
  - `out_valid` ← 1 on that same edge.
- `in_ready` = (state == RUN) && (!`out_valid` || `out_ready`). This is a one-deep output register with no skid, and it stalls input every cycle the output is held.
- Simultaneous output handshake and new window completion: the register is overwritten and `out_valid` stays 1, with no bubble.
- Reset mid-frame: all state is cleared asynchronously and outputs take their reset values. The partial frame is lost.

## Timing
- Reset values: `in_ready`=0, `out_valid`=0, `out_data`=0, `busy`=0, `done`=0. The FSM resets to IDLE.
- `in_ready` rises the cycle after an accepted `start`.
- Latency: `out_valid` is high the cycle after the window-completing input handshake.
- Output handshake: `out_data` is stable while `out_valid && !out_ready`.
- `done` occurs ≥ 2 cycles after the last input handshake, and exactly 2 cycles when `out_ready`=1.
- Throughput: 1 sample/cycle with `out_ready` tied high.

## Configuration
- `POOL_AVG_EN` defined:
  - Average mode is available.
  - ACC_W = DATA_W + 2·log2 P.
  - P must be a power of two; elaboration `$error` otherwise.
- `POOL_AVG_EN` undefined:
  - `mode` is ignored.
  - ACC_W = DATA_W.
  - The adder is not built.
  - Any P is legal.

## Structure
- Package `pool_pkg`: FSM state enum (`IDLE`, `RUN`, `DRAIN`, `FIN`), `pool_mode_e` (`POOL_MAX`, `POOL_AVG`), and the ACC_W function.
- Sub-module `pool_row_buffer`: Q-entry accumulator array.
  - One read port, combinational at `wc`.
  - One write port.
  - Inferred as distributed RAM.
- Top level: FSM, counters, op unit, output register.

## Test plan
- M=4, P=2, max, ramp 0..15, `out_ready`=1 → outputs 5, 7, 13, 15; `done` 2 cycles after the sample of value 15.
- M=5, P=2, ramp 0..24 → outputs 6, 8, 16, 18; column 4 and row 4 are discarded; 25 input handshakes total.
- M=4, P=2, all samples −3, plus −1 at (1,1) → first output −1, others −3 (signed compare).
- M=4, P=2, `out_ready` held low for 5 cycles at the first result → `in_ready`=0 throughout the hold; `out_data`=5 stable; no loss or duplication.
- `POOL_AVG_EN`, M=4, P=2, avg, ramp 0..15 → outputs 2, 4, 10, 12.
- Deassert `external_reset_n` after 6 samples → all outputs at reset values immediately. A new `start` with ramp 0..15 yields 5, 7, 13, 15.
